// File: rtl/sdram_fb_arbiter.sv
// sdram_fb_arbiter: round-robin burst arbiter between a camera write channel
// and a display read channel, with 1/2/3 frame-buffer rotation in the bank field.
module sdram_fb_arbiter #(
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned BANK_W  = 2,
   parameter int unsigned LEN_W   = 10,
   parameter int unsigned NUM_BUF = 2
) (
   input  logic                     i_sysclk,
   input  logic                     i_sysrst_n,
   input  logic                     init_end,
   input  logic                     wr_rst,
   input  logic                     rd_rst,
   input  logic                     read_valid,
   input  logic [LEN_W-1:0]         wr_fifo_num,
   input  logic [LEN_W-1:0]         rd_fifo_num,
   input  logic [LEN_W-1:0]         wr_burst_len,
   input  logic [LEN_W-1:0]         rd_burst_len,
   input  logic [ADDR_W-BANK_W-1:0] wr_b_addr,
   input  logic [ADDR_W-BANK_W-1:0] wr_e_addr,
   input  logic [ADDR_W-BANK_W-1:0] rd_b_addr,
   input  logic [ADDR_W-BANK_W-1:0] rd_e_addr,
   input  logic                     sdram_wr_ack,
   input  logic                     sdram_rd_ack,
   output logic                     sdram_wr_req,
   output logic                     sdram_rd_req,
   output logic [ADDR_W-1:0]        sdram_wr_addr,
   output logic [ADDR_W-1:0]        sdram_rd_addr,
   output logic [1:0]               wr_buf,
   output logic [1:0]               rd_buf,
   output logic                     wr_frame_done,
   output logic                     rd_frame_done,
   output logic                     frame_drop
);
   localparam int unsigned OFF_W = ADDR_W - BANK_W;
   localparam int unsigned SUM_W = OFF_W + 1;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

   state_t           state_q, state_d;
   logic [OFF_W-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
   logic [1:0]       wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, latest_q, latest_d;
   logic             fresh_q, fresh_d, last_rd_q, last_rd_d;
   logic             wr_skip_q, wr_skip_d, rd_skip_q, rd_skip_d;
   logic             wr_req_q, wr_req_d, rd_req_q, rd_req_d;
   logic             wr_done_q, wr_done_d, rd_done_q, rd_done_d, drop_q, drop_d;
   logic             wr_ack_dly_q, rd_ack_dly_q;

   logic             wr_elig_c, rd_elig_c, wr_fall_c, rd_fall_c;
   logic [SUM_W-1:0] wr_sum_c, rd_sum_c;
   logic [1:0]       wr_nxt_c;

   assign wr_elig_c = init_end & (wr_fifo_num >= wr_burst_len);
   assign rd_elig_c = init_end & read_valid & (rd_fifo_num < rd_burst_len);
   assign wr_fall_c = wr_ack_dly_q & ~sdram_wr_ack;
   assign rd_fall_c = rd_ack_dly_q & ~sdram_rd_ack;
   assign wr_sum_c  = SUM_W'(wr_off_q) + SUM_W'(wr_burst_len);
   assign rd_sum_c  = SUM_W'(rd_off_q) + SUM_W'(rd_burst_len);

   // Triple buffering: lowest index that is neither the finished buffer nor the one being displayed
   always_comb begin
      wr_nxt_c = 2'd2;
      if (wr_buf_q != 2'd0 && rd_buf_q != 2'd0)      wr_nxt_c = 2'd0;
      else if (wr_buf_q != 2'd1 && rd_buf_q != 2'd1) wr_nxt_c = 2'd1;
   end

   // Next-state, address advance and buffer rotation
   always_comb begin
      logic wr_end, rd_end;
      state_d   = state_q;
      wr_off_d  = wr_off_q;
      rd_off_d  = rd_off_q;
      wr_buf_d  = wr_buf_q;
      rd_buf_d  = rd_buf_q;
      latest_d  = latest_q;
      fresh_d   = fresh_q;
      last_rd_d = last_rd_q;
      wr_skip_d = wr_skip_q;
      rd_skip_d = rd_skip_q;
      wr_req_d  = wr_req_q;
      rd_req_d  = rd_req_q;
      wr_done_d = 1'b0;
      rd_done_d = 1'b0;
      drop_d    = 1'b0;
      wr_end    = 1'b0;
      rd_end    = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_elig_c && (!rd_elig_c || last_rd_q)) begin
               state_d   = WR_REQ;
               wr_req_d  = 1'b1;
               last_rd_d = 1'b0;
            end else if (rd_elig_c) begin
               state_d   = RD_REQ;
               rd_req_d  = 1'b1;
               last_rd_d = 1'b1;
            end
         end
         WR_REQ: begin
            // An accepted burst must be tracked even if a restart arrives with the ack
            if (sdram_wr_ack) begin
               state_d   = WR_BURST;
               wr_req_d  = 1'b0;
               wr_skip_d = wr_rst;
            end else if (!init_end || wr_rst) begin
               state_d  = IDLE;
               wr_req_d = 1'b0;
            end
         end
         WR_BURST: begin
            if (wr_rst) wr_skip_d = 1'b1;
            if (wr_fall_c) begin
               state_d   = IDLE;
               wr_skip_d = 1'b0;
               if (!(wr_skip_q || wr_rst)) begin
                  if (wr_sum_c < {1'b0, wr_e_addr}) wr_off_d = wr_sum_c[OFF_W-1:0];
                  else                              wr_end   = 1'b1;
               end
            end
         end
         RD_REQ: begin
            if (sdram_rd_ack) begin
               state_d   = RD_BURST;
               rd_req_d  = 1'b0;
               rd_skip_d = rd_rst;
            end else if (!init_end || rd_rst) begin
               state_d  = IDLE;
               rd_req_d = 1'b0;
            end
         end
         RD_BURST: begin
            if (rd_rst) rd_skip_d = 1'b1;
            if (rd_fall_c) begin
               state_d   = IDLE;
               rd_skip_d = 1'b0;
               if (!(rd_skip_q || rd_rst)) begin
                  if (rd_sum_c < {1'b0, rd_e_addr}) rd_off_d = rd_sum_c[OFF_W-1:0];
                  else                              rd_end   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Writer frame end is applied before the reader so a same-cycle reader picks it up
      if (wr_end) begin
         wr_off_d  = wr_b_addr;
         wr_done_d = 1'b1;
         latest_d  = wr_buf_q;
         fresh_d   = 1'b1;
         if (NUM_BUF == 1)      wr_buf_d = 2'd0;
         else if (NUM_BUF == 2) wr_buf_d = {1'b0, ~wr_buf_q[0]};
         else                   wr_buf_d = wr_nxt_c;
      end

      if (rd_end) begin
         rd_off_d  = rd_b_addr;
         rd_done_d = 1'b1;
         if (fresh_d) begin
            rd_buf_d = latest_d;
            fresh_d  = 1'b0;
         end else if (NUM_BUF != 1) begin
            drop_d = 1'b1;
         end
      end

      // Channel restarts take effect immediately on their own channel only
      if (wr_rst) begin
         wr_off_d = wr_b_addr;
         wr_buf_d = 2'd0;
      end
      if (rd_rst) begin
         rd_off_d = rd_b_addr;
         rd_buf_d = 2'd0;
      end
   end

   // State and output registers; last-served resets to read so write wins the first tie
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         state_q      <= IDLE;
         wr_off_q     <= '0;
         rd_off_q     <= '0;
         wr_buf_q     <= 2'd0;
         rd_buf_q     <= 2'd0;
         latest_q     <= 2'd0;
         fresh_q      <= 1'b0;
         last_rd_q    <= 1'b1;
         wr_skip_q    <= 1'b0;
         rd_skip_q    <= 1'b0;
         wr_req_q     <= 1'b0;
         rd_req_q     <= 1'b0;
         wr_done_q    <= 1'b0;
         rd_done_q    <= 1'b0;
         drop_q       <= 1'b0;
         wr_ack_dly_q <= 1'b0;
         rd_ack_dly_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_off_q     <= wr_off_d;
         rd_off_q     <= rd_off_d;
         wr_buf_q     <= wr_buf_d;
         rd_buf_q     <= rd_buf_d;
         latest_q     <= latest_d;
         fresh_q      <= fresh_d;
         last_rd_q    <= last_rd_d;
         wr_skip_q    <= wr_skip_d;
         rd_skip_q    <= rd_skip_d;
         wr_req_q     <= wr_req_d;
         rd_req_q     <= rd_req_d;
         wr_done_q    <= wr_done_d;
         rd_done_q    <= rd_done_d;
         drop_q       <= drop_d;
         wr_ack_dly_q <= sdram_wr_ack;
         rd_ack_dly_q <= sdram_rd_ack;
      end
   end

   assign sdram_wr_req  = wr_req_q;
   assign sdram_rd_req  = rd_req_q;
   assign sdram_wr_addr = {BANK_W'(wr_buf_q), wr_off_q};
   assign sdram_rd_addr = {BANK_W'(rd_buf_q), rd_off_q};
   assign wr_buf        = wr_buf_q;
   assign rd_buf        = rd_buf_q;
   assign wr_frame_done = wr_done_q;
   assign rd_frame_done = rd_done_q;
   assign frame_drop    = drop_q;

endmodule
